// File: rtl/io_map_pkg.sv
// io_map_pkg: register offsets, debounce states and 7-segment table for io_bus_ctrl
package io_map_pkg;
  localparam logic [7:0] IO_OFS_SW       = 8'h00;
  localparam logic [7:0] IO_OFS_KEY      = 8'h04;
  localparam logic [7:0] IO_OFS_KEYEVT   = 8'h08;
  localparam logic [7:0] IO_OFS_HEXVAL   = 8'h0C;
  localparam logic [7:0] IO_OFS_HEXBLANK = 8'h10;
  localparam logic [7:0] IO_OFS_LED      = 8'h14;

  typedef enum logic [1:0] {DB_UP, DB_DN_WAIT, DB_DOWN, DB_UP_WAIT} db_state_e;

  // Active-low segments, bit0 = a .. bit6 = g; element 0 is the last in the list.
  localparam logic [15:0][6:0] SEG_TAB = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic logic [6:0] seg7(input logic [3:0] n);
    return SEG_TAB[n];
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: 2-flop synchroniser and debounce FSM for one active-low key
//   clock, reset   : clock, async active-high reset
//   key_n_i        : raw key pin, 0 = pressed
//   key_lvl_o      : debounced level, 1 = pressed
//   rise_o         : high in the cycle whose edge accepts a press
module key_debounce import io_map_pkg::*; #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clock,
  input  logic reset,
  input  logic key_n_i,
  output logic key_lvl_o,
  output logic rise_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] sync_q;
  logic k_s;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic done;
  assign k_s = ~sync_q[1];
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + 1'b1;
  // cnt_q counts stable samples already seen; the current one makes DEBOUNCE_CYCLES.
  assign done = cnt_q == LAST;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      DB_UP: if (k_s) begin
        state_d = (DEBOUNCE_CYCLES <= 1) ? DB_DOWN : DB_DN_WAIT;
        cnt_d = CW'(1);
      end
      DB_DN_WAIT: if (!k_s) state_d = DB_UP;
        else if (done) state_d = DB_DOWN;
        else cnt_d = cnt_inc;
      DB_DOWN: if (!k_s) begin
        state_d = (DEBOUNCE_CYCLES <= 1) ? DB_UP : DB_UP_WAIT;
        cnt_d = CW'(1);
      end
      default: if (k_s) state_d = DB_DOWN;
        else if (done) state_d = DB_UP;
        else cnt_d = cnt_inc;
    endcase
  end
  assign key_lvl_o = (state_q == DB_DOWN) || (state_q == DB_UP_WAIT);
  assign rise_o = (state_d == DB_DOWN) && ((state_q == DB_UP) || (state_q == DB_DN_WAIT));
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sync_q <= 2'b11;
      state_q <= DB_UP;
      cnt_q <= '0;
    end else begin
      sync_q <= {sync_q[0], key_n_i};
      state_q <= state_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/io_bus_ctrl.sv
// io_bus_ctrl: memory-mapped switch/key/7-segment/LED controller on the CPU data bus
//   clock, reset          : clock, async active-high reset
//   addr, wdata, we, re   : CPU data bus access
//   rdata, io_hit         : combinational load data and window decode
//   sw, key               : raw switches and active-low keys
//   hex5..hex0, led       : active-low digit segments, LED drive
module io_bus_ctrl import io_map_pkg::*; #(
  parameter logic [31:0] IO_BASE = 32'hFFFF_FF00,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        we,
  input  logic        re,
  output logic [31:0] rdata,
  output logic        io_hit,
  input  logic [9:0]  sw,
  input  logic [3:0]  key,
  output logic [6:0]  hex5,
  output logic [6:0]  hex4,
  output logic [6:0]  hex3,
  output logic [6:0]  hex2,
  output logic [6:0]  hex1,
  output logic [6:0]  hex0,
  output logic [9:0]  led
);
  logic [9:0] sw_m_q, sw_s_q, led_q;
  logic [3:0] key_lvl, key_rise, evt_q, evt_d;
  logic [23:0] hexval_q;
  logic [5:0] blank_q;
  logic [5:0][6:0] hex_w;
  logic [7:0] ofs;
  logic rd_en, wr_en;
  logic unused;
  assign unused = ^{addr[1:0], wdata[31:24]};
  assign io_hit = addr[31:8] == IO_BASE[31:8];
  assign ofs = {addr[7:2], 2'b00};
  assign rd_en = re & io_hit;
  assign wr_en = we & io_hit;
  for (genvar g = 0; g < 4; g++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock(clock),
      .reset(reset),
      .key_n_i(key[g]),
      .key_lvl_o(key_lvl[g]),
      .rise_o(key_rise[g])
    );
  end
  for (genvar g = 0; g < 6; g++) begin : g_hex
    assign hex_w[g] = blank_q[g] ? 7'h7F : seg7(hexval_q[4*g +: 4]);
  end
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_w;
  assign led = led_q;
  always_comb
    rdata = !rd_en                  ? 32'b0 :
            ofs == IO_OFS_SW        ? {22'b0, sw_s_q} :
            ofs == IO_OFS_KEY       ? {28'b0, key_lvl} :
            ofs == IO_OFS_KEYEVT    ? {28'b0, evt_q} :
            ofs == IO_OFS_HEXVAL    ? {8'b0, hexval_q} :
            ofs == IO_OFS_HEXBLANK  ? {26'b0, blank_q} :
            ofs == IO_OFS_LED       ? {22'b0, led_q} : 32'b0;
  // A read returns every pending bit, so all are cleared; a same-cycle rise survives.
  assign evt_d = ((rd_en && ofs == IO_OFS_KEYEVT) ? 4'b0 : evt_q) | key_rise;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      sw_m_q <= '0;
      sw_s_q <= '0;
      evt_q <= '0;
      hexval_q <= '0;
      blank_q <= 6'h3F;
      led_q <= '0;
    end else begin
      sw_m_q <= sw;
      sw_s_q <= sw_m_q;
      evt_q <= evt_d;
      if (wr_en && ofs == IO_OFS_HEXVAL) hexval_q <= wdata[23:0];
      if (wr_en && ofs == IO_OFS_HEXBLANK) blank_q <= wdata[5:0];
      if (wr_en && ofs == IO_OFS_LED) led_q <= wdata[9:0];
    end
endmodule

// File: tb/tb_io_bus_ctrl.sv
// tb_io_bus_ctrl: directed plus random self-checking bench for io_bus_ctrl
module tb_io_bus_ctrl;
  localparam int D = 4;
  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  logic clock = 1'b0;
  logic reset;
  logic [31:0] addr, wdata, rdata;
  logic we, re, io_hit;
  logic [9:0] sw, led;
  logic [3:0] key;
  logic [6:0] hex5, hex4, hex3, hex2, hex1, hex0;
  logic [6:0] hx [6];
  int checks = 0;
  int errors = 0;

  io_bus_ctrl #(.IO_BASE(BASE), .DEBOUNCE_CYCLES(D)) dut (
    .clock(clock), .reset(reset), .addr(addr), .wdata(wdata), .we(we), .re(re),
    .rdata(rdata), .io_hit(io_hit), .sw(sw), .key(key),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .led(led)
  );

  always #5 clock = ~clock;
  assign hx[0] = hex0;
  assign hx[1] = hex1;
  assign hx[2] = hex2;
  assign hx[3] = hex3;
  assign hx[4] = hex4;
  assign hx[5] = hex5;

  // Reference model: pins pass through two-stage pipes; a key level flips once
  // D consecutive synchronised samples disagree with it.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] m_k1, m_k2, m_lvl, m_evt;
  logic [9:0] m_sw1, m_sw2, m_led;
  logic [23:0] m_hex;
  logic [5:0] m_blank;
  int m_run [4];

  function automatic logic in_win();
    return addr[31:8] == 24'hFFFFFF;
  endfunction

  function automatic logic [31:0] exp_rd();
    if (!re || !in_win()) return 32'b0;
    case (addr[7:2])
      6'd0: return {22'b0, m_sw2};
      6'd1: return {28'b0, m_lvl};
      6'd2: return {28'b0, m_evt};
      6'd3: return {8'b0, m_hex};
      6'd4: return {26'b0, m_blank};
      6'd5: return {22'b0, m_led};
      default: return 32'b0;
    endcase
  endfunction

  function automatic logic [6:0] exp_hex(int n);
    return m_blank[n] ? 7'h7F : seg_tab[m_hex[4*n +: 4]];
  endfunction

  function automatic void model_reset();
    m_k1 = 4'hF; m_k2 = 4'hF; m_lvl = 4'h0; m_evt = 4'h0;
    m_sw1 = '0; m_sw2 = '0; m_led = '0; m_hex = '0; m_blank = 6'h3F;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endfunction

  function automatic void model_edge();
    logic [3:0] rise = 4'h0;
    logic ks;
    for (int k = 0; k < 4; k++) begin
      ks = ~m_k2[k];
      if (ks != m_lvl[k]) begin
        m_run[k]++;
        if (m_run[k] == D) begin
          m_lvl[k] = ks;
          m_run[k] = 0;
          rise[k] = ks;
        end
      end else m_run[k] = 0;
    end
    if (re && in_win() && addr[7:2] == 6'd2) m_evt = 4'h0;
    m_evt = m_evt | rise;
    if (we && in_win())
      case (addr[7:2])
        6'd3: m_hex = wdata[23:0];
        6'd4: m_blank = wdata[5:0];
        6'd5: m_led = wdata[9:0];
        default: ;
      endcase
    m_k2 = m_k1; m_k1 = key; m_sw2 = m_sw1; m_sw1 = sw;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outs();
    for (int n = 0; n < 6; n++) chk("hex", 32'(hx[n]), 32'(exp_hex(n)));
    chk("led", 32'(led), 32'(m_led));
  endtask

  task automatic step();
    #1 chk("rdata", rdata, exp_rd());
    chk("io_hit", 32'(io_hit), 32'(in_win()));
    @(posedge clock);
    model_edge();
    #1 check_outs();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1 check_outs();
    we = 1'b1; addr = BASE + 32'h14; wdata = 32'hFFFF_FFFF;
    @(posedge clock);
    #1 reset = 1'b0;
    we = 1'b0;
  endtask

  initial begin
    logic [31:0] rst_exp [7] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h3F, 32'h0, 32'h0};
    logic [7:0] rst_ofs [7] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h40};
    reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; sw = '0; key = 4'hF;
    #2 do_reset();
    #1 chk("rst_led", 32'(led), 32'h0);
    chk("rst_hex5", 32'(hex5), 32'h7F);
    chk("rst_hex0", 32'(hex0), 32'h7F);
    chk("rst_rdata", rdata, 32'h0);
    re = 1'b1;
    for (int i = 0; i < 7; i++) begin
      addr = BASE + 32'(rst_ofs[i]);
      #1 chk("rst_read", rdata, rst_exp[i]);
      step();
    end
    // key[2] held low for 10 edges
    addr = BASE + 32'h04;
    key[2] = 1'b0;
    repeat (5) step();
    #1 chk("key_before_e6", rdata, 32'h0);
    step();
    #1 chk("key_at_e6", rdata, 32'h4);
    repeat (4) step();
    key[2] = 1'b1;
    repeat (8) step();
    addr = BASE + 32'h08;
    #1 chk("evt_first", rdata, 32'h4);
    step();
    #1 chk("evt_second", rdata, 32'h0);
    step();
    // 3-cycle glitch on key[0]
    addr = BASE + 32'h04;
    key[0] = 1'b0;
    repeat (3) step();
    key[0] = 1'b1;
    repeat (8) step();
    #1 chk("glitch_key", rdata, 32'h0);
    addr = BASE + 32'h08;
    #1 chk("glitch_evt", rdata, 32'h0);
    step();
    // segment display
    re = 1'b0; we = 1'b1;
    addr = BASE + 32'h0C; wdata = 32'h00AB_CDEF;
    step();
    addr = BASE + 32'h10; wdata = 32'h0;
    step();
    we = 1'b0;
    #1 chk("hex5_A", 32'(hex5), 32'h08);
    chk("hex4_b", 32'(hex4), 32'h03);
    chk("hex3_C", 32'(hex3), 32'h46);
    chk("hex2_d", 32'(hex2), 32'h21);
    chk("hex1_E", 32'(hex1), 32'h06);
    chk("hex0_F", 32'(hex0), 32'h0E);
    we = 1'b1; wdata = 32'h1;
    step();
    we = 1'b0;
    #1 chk("hex0_blank", 32'(hex0), 32'h7F);
    chk("hex1_kept", 32'(hex1), 32'h06);
    re = 1'b1; addr = BASE + 32'h0E;
    #1 chk("hexval_read", rdata, 32'h00AB_CDEF);
    step();
    // read in the same cycle as a write returns the old value
    addr = BASE + 32'h14; we = 1'b1; wdata = 32'h155;
    #1 chk("rdw_old", rdata, 32'h0);
    step();
    we = 1'b0;
    #1 chk("rdw_new", rdata, 32'h155);
    chk("led_155", 32'(led), 32'h155);
    step();
    // writes outside the window or to unmapped offsets are ignored
    re = 1'b0; we = 1'b1; wdata = 32'h3FF;
    addr = 32'h0000_0014;
    step();
    addr = BASE + 32'h40;
    step();
    we = 1'b0;
    #1 chk("led_untouched", 32'(led), 32'h155);
    re = 1'b1;
    #1 chk("unmapped_read", rdata, 32'h0);
    step();
    // press completes in the same cycle as a KEYEVT read
    addr = BASE + 32'h08;
    key[1] = 1'b0;
    repeat (5) step();
    #1 chk("race_read", rdata, 32'h0);
    step();
    #1 chk("race_next", rdata, 32'h2);
    step();
    key[1] = 1'b1;
    repeat (8) step();
    // reset in the middle of a debounce and after an LED write
    re = 1'b0; we = 1'b1; addr = BASE + 32'h14; wdata = 32'h3FF;
    step();
    we = 1'b0;
    #1 chk("led_3ff", 32'(led), 32'h3FF);
    key[3] = 1'b0;
    repeat (4) step();
    do_reset();
    #1 chk("led_after_rst", 32'(led), 32'h0);
    re = 1'b1; addr = BASE + 32'h04;
    repeat (5) step();
    #1 chk("post_rst_e5", rdata, 32'h0);
    step();
    #1 chk("post_rst_e6", rdata, 32'h8);
    addr = BASE + 32'h08;
    #1 chk("post_rst_evt", rdata, 32'h8);
    step();
    key[3] = 1'b1;
    repeat (8) step();
    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      int j;
      j = int'($urandom_range(3));
      if ($urandom_range(5) == 0) key[j] = ~key[j];
      if ($urandom_range(15) == 0) sw = 10'($urandom);
      we = $urandom_range(3) == 0;
      re = $urandom_range(1) == 1;
      addr = ($urandom_range(7) == 0) ? 32'($urandom)
                                       : {24'hFFFFFF, 6'($urandom_range(7)), 2'($urandom)};
      wdata = 32'($urandom);
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/io_bus_ctrl.md
# io_bus_ctrl

Memory-mapped I/O controller between the single-cycle CPU data bus and the board peripherals: switches, push-keys, six 7-segment digits and ten LEDs. It decodes CPU loads and stores in the I/O window and synchronises and debounces the keys. It latches key-press events for software polling and holds the output registers that drive the displays. It sits beside the data memory inside the computer top level, and its read data is muxed with memory read data by address.

## Interface
Parameters:
- `IO_BASE`, 32'hFFFF_FF00: I/O window base; window is `IO_BASE[31:8]`, 256 bytes.
- `DEBOUNCE_CYCLES`, 250000: consecutive stable cycles before a key level is accepted (5 ms at 50 MHz); benches use 4.

Ports:
- `clock`  in  1  single clock (the CPU data-memory clock domain)
- `reset`  in  1  asynchronous, active-high reset
- `addr`  in  32  CPU byte address (ALU result)
- `wdata`  in  32  CPU store data
- `we`  in  1  store strobe, sampled at `clock` rising edge
- `re`  in  1  load strobe
- `rdata`  out  32  load data, combinational
- `io_hit`  out  1  `addr[31:8] == IO_BASE[31:8]`, combinational
- `sw`  in  10  raw switches, asynchronous
- `key`  in  4  raw keys, active-low (0 = pressed), asynchronous
- `hex5`..`hex0`  out  7 each  active-low segments; bit0 = a … bit6 = g
- `led`  out  10  LED drive, 1 = lit

## Operation
- Register select uses `addr[7:2]` when `io_hit`. Unmapped offsets read 0 and ignore writes. `addr[1:0]` is ignored.
- 0x00 SW (RO): `{22'b0, sw_s}`. `sw_s` is `sw` through a 2-flop synchroniser.
- 0x04 KEY (RO): `{28'b0, key_lvl}`. Debounced level; 1 = pressed.
- 0x08 KEYEVT (RO, clear-on-read): `{28'b0, evt}`.
  - A `key_lvl` 0→1 transition sets the bit.
  - A qualified read (`re & io_hit` at offset 0x08) clears, at that edge, the bits returned in `rdata`.
  - A set in the same cycle as the clear wins; the bit stays 1.
- 0x0C HEXVAL (RW): 24-bit value in bits [23:0]; bits [31:24] read 0. `hexN` shows nibble `[4N+3:4N]`.
- 0x10 HEXBLANK (RW): bits [5:0]. Bit N = 1 forces `hexN` = 7'h7F (all segments off).
- 0x14 LED (RW): bits [9:0] drive `led`.
- Writes require `we & io_hit` and take effect at the rising edge. `rdata` = 0 when `!(re & io_hit)`.
- Segment encoding, active-low:
  - 0→7'h40, 1→7'h79, 2→7'h24, 3→7'h30, 4→7'h19, 5→7'h12, 6→7'h02, 7→7'h78
  - 8→7'h00, 9→7'h10, A→7'h08, b→7'h03, C→7'h46, d→7'h21, E→7'h06, F→7'h0E
- Debounce, per key, on the synchronised inverted key `k_s` (1 = pressed). States:
  - UP: `key_lvl` = 0. On `k_s`=1, load counter = 1 and go to DN_WAIT.
  - DN_WAIT: if `k_s`=0, go to UP. Otherwise, when counter = `DEBOUNCE_CYCLES`, go to DOWN, set `key_lvl` = 1 and pulse the rise. Else increment the counter.
  - DOWN: `key_lvl` = 1. On `k_s`=0, load counter = 1 and go to UP_WAIT.
  - UP_WAIT: mirror of DN_WAIT; the release produces no event.
- Counter width: `$clog2(DEBOUNCE_CYCLES+1)`. It saturates and never wraps.

## Timing
- Reset values:
  - synchroniser flops: switches 0, keys 1 (released)
  - all FSMs UP; `key_lvl` 0, `evt` 0
  - HEXVAL 0, HEXBLANK 6'h3F, LED 0
  - so `hex5`..`hex0` = 7'h7F, `led` = 0, `rdata` = 0
- Reset is asynchronous; assertion mid-debounce or mid-access discards all state immediately. A store in the reset-release cycle is dropped.
- `sw` change → visible in SW read after 2 rising edges.
- `key` press held stable → `key_lvl` and `evt` set at edge 2 + `DEBOUNCE_CYCLES` after the pin change.
- A glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles produces no change and no event.
- Write → `hex*`/`led` update at the same edge, with combinational decode. A read in the same cycle as a write returns the old value.
- Load data is combinational in the access cycle. Clear-on-read side effects occur only at the edge ending that cycle.

## Structure
- Package `io_map_pkg`: `IO_OFS_SW`, `IO_OFS_KEY`, `IO_OFS_KEYEVT`, `IO_OFS_HEXVAL`, `IO_OFS_HEXBLANK`, `IO_OFS_LED`, the debounce state enum, and the 16-entry segment constant table.
- Sub-module `key_debounce`: synchroniser plus FSM plus counter, with `key_lvl` and `rise` outputs. Instantiated 4× via generate.
- Segment decode is a function in the package, applied six times.

## Test plan
- Reset then idle → all `hexN` = 7'h7F, `led` = 0; reads of 0x00–0x14 return reset values; unmapped offset 0x40 reads 0.
- `DEBOUNCE_CYCLES`=4; `key[2]` low for 10 cycles → KEY = 4'b0100 at edge 6. First read of 0x08 returns 4'b0100, second read returns 0.
- `key[0]` low for 3 cycles, then high → KEY and KEYEVT stay 0.
- Store 32'h00AB_CDEF to 0x0C and 6'h00 to 0x10 → hex5..hex0 = 7'h08, 03, 46, 21, 06, 0E. Store 6'h01 → `hex0` = 7'h7F.
- Press completes in the same cycle as a read of 0x08 → read returns 0, and the bit reads 1 on the next read.
- `reset` asserted mid-DN_WAIT and after an LED write of 10'h3FF → `led` = 0 immediately. No event after release, even with the key still held, until a full `DEBOUNCE_CYCLES` elapse again.
